// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and baud divider helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

    // Clocks per oversample tick; shared with the transmitter.
    function automatic int unsigned div_calc(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head output.
module sync_fifo #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned WIDTH   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_AW:0] wptr_q, wptr_d;
    logic [FIFO_AW:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             empty, full;
    logic             push_eff, pop_eff;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign pop_eff  = pop_i & ~empty;
    assign push_eff = push_i & (~full | pop_i);

    always_comb begin
        wptr_d = push_eff ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop_eff ? rptr_q + 1'b1 : rptr_q;
        // Head register: bypass the write data when the new head is the slot being written.
        if (rptr_d == wptr_d) begin
            rdata_d = '0;
        end else if (push_eff && (rptr_d == wptr_q)) begin
            rdata_d = wdata_i;
        end else begin
            rdata_d = mem_q[rptr_d[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wptr_q[FIFO_AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign empty_o = empty;
    assign full_o  = full;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: synchronizer, tick generator, deframing FSM and receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 100000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int unsigned DIV   = div_calc(SYS_CLK_FREQ, BAUD_RATE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             sync1_q, rx_s_q, rx_prev_q;
    logic             fall;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick, restart;

    rx_state_t        state_q, state_d;
    logic [3:0]       tc_q, tc_d;
    logic [2:0]       bc_q, bc_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             overrun_q, overrun_d;

    logic [7:0]       data_al;
    logic             parity_exp, par_bad;
    logic             push;
    logic             fifo_full;

    assign fall = rx_prev_q & ~rx_s_q;
    assign tick = (div_cnt_q == DIV_W'(DIV - 1));

    // Bits arrive LSB first into the top of the shifter; align short characters to bit 0.
    assign data_al    = shift_q >> (8 - DATA_BITS);
    assign parity_exp = (^data_al) ^ (PARITY_ODD != 0);
    assign par_bad    = (PARITY_EN != 0) && (par_q != parity_exp);

    always_comb begin
        if (restart || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        tc_d         = tc_q;
        bc_d         = bc_q;
        shift_d      = shift_q;
        par_d        = par_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        push         = 1'b0;
        restart      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    tc_d    = 4'd0;
                    restart = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tc_q == 4'd7) begin
                        // A line back high at mid-start is a glitch, not a character.
                        if (rx_s_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            tc_d    = 4'd0;
                            bc_d    = 3'd0;
                        end
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        if (bc_q == 3'(DATA_BITS - 1)) begin
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bc_d = bc_q + 3'd1;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        par_d   = rx_s_q;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        state_d = ST_IDLE;
                        if (!rx_s_q) begin
                            frame_err_d = 1'b1;
                        end else if (par_bad) begin
                            parity_err_d = 1'b1;
                        end else if (fifo_full && !rd_en) begin
                            overrun_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_cnt_q    <= '0;
            state_q      <= ST_IDLE;
            tc_q         <= 4'd0;
            bc_q         <= 3'd0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= rx;
            rx_s_q       <= sync1_q;
            rx_prev_q    <= rx_s_q;
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            tc_q         <= tc_d;
            bc_q         <= bc_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    sync_fifo #(
        .FIFO_AW (FIFO_AW),
        .WIDTH   (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (data_al),
        .pop_i   (rd_en),
        .rdata_o (rd_data),
        .empty_o (rx_empty),
        .full_o  (fifo_full)
    );

    assign rx_full    = fifo_full;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
